// File: rtl/adc_emu_pkg.sv
// Shared constants, FSM state type and the config-to-sample mapping for the
// LTC2308-style ADC emulator.
package adc_emu_pkg;

  localparam int unsigned CFG_W = 6;
  localparam int unsigned RES_W = 12;
  localparam int unsigned NCH   = 8;
  localparam int unsigned TBL_W = RES_W * NCH;

  // Config word layout {S/D, O/S, S1, S0, UNI, SLP}
  localparam int unsigned CFG_SLP = 0;
  localparam int unsigned CFG_UNI = 1;
  localparam int unsigned CFG_S0  = 2;
  localparam int unsigned CFG_S1  = 3;
  localparam int unsigned CFG_OS  = 4;
  localparam int unsigned CFG_SD  = 5;

  localparam logic [CFG_W-1:0] CFG_RESET = 6'b100010;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CONVERT
  } state_t;

  function automatic logic [RES_W-1:0] cfg_to_result(
    input logic [CFG_W-1:0] cfg,
    input logic [TBL_W-1:0] tbl
  );
    logic [2:0]       ch;
    logic [RES_W-1:0] raw;
    logic [RES_W-1:0] res;
    ch  = {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
    raw = tbl[RES_W*ch +: RES_W];
    res = raw;
    if (!cfg[CFG_SD]) begin
      res = '0;
    end else if (!cfg[CFG_UNI]) begin
      res = raw ^ 12'h800;
    end
    if (cfg[CFG_SLP]) begin
      res = '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/adc_spi_responder_if.sv
// SPI pin bundle between the ADC master and the emulated converter.
interface adc_spi_responder_if;
  logic adc_sclk;
  logic adc_cs_n;
  logic adc_din;
  logic adc_dout;

  modport master (output adc_sclk, output adc_cs_n, output adc_din, input adc_dout);
  modport slave  (input adc_sclk, input adc_cs_n, input adc_din, output adc_dout);
endinterface

// File: rtl/spi_pin_sync.sv
// Synchronises the asynchronous SPI pins into clk and produces single-cycle
// edge strobes for sclk and cs_n plus a synchronised din.
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic cs_n,
  input  logic din,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic din_s
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] din_sync;
  logic                   sclk_prev;
  logic                   cs_prev;

  // cs_n history clears to 0 so a frame already in progress at reset release
  // never produces a fall; only the master's next genuine fall starts a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      din_sync  <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_prev;
  assign cs_rise   = cs_sync[SYNC_STAGES-1] & ~cs_prev;
  assign cs_fall   = ~cs_sync[SYNC_STAGES-1] & cs_prev;
  assign din_s     = din_sync[SYNC_STAGES-1];

endmodule

// File: rtl/adc_spi_responder.sv
// Emulated 12-bit 8-channel SPI ADC: accepts a 6-bit config per frame and
// returns the sample selected by the previous frame's config.
module adc_spi_responder
  import adc_emu_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  adc_spi_responder_if.slave  spi,
  input  logic [TBL_W-1:0]    sample_table,
  output logic [CFG_W-1:0]    cfg_word,
  output logic                cfg_valid,
  output logic                busy,
  output logic                err_early,
  output logic                err_short,
  output logic [15:0]         frame_count
);

  localparam int unsigned CONV_W   = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [3:0]  CFG_BITS = 4'(CFG_W);

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, din_s;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .sclk      (spi.adc_sclk),
    .cs_n      (spi.adc_cs_n),
    .din       (spi.adc_din),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .din_s     (din_s)
  );

  state_t            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [CFG_W-1:0]  shreg_q, shreg_d;
  logic [RES_W-1:0]  tx_q, tx_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [CONV_W-1:0] conv_cnt_q, conv_cnt_d;
  logic              cfg_valid_q, cfg_valid_d;
  logic              err_early_q, err_early_d;
  logic              err_short_q, err_short_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      tx_q        <= '0;
      result_q    <= '0;
      cfg_q       <= CFG_RESET;
      frame_cnt_q <= '0;
      conv_cnt_q  <= '0;
      cfg_valid_q <= 1'b0;
      err_early_q <= 1'b0;
      err_short_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
      result_q    <= result_d;
      cfg_q       <= cfg_d;
      frame_cnt_q <= frame_cnt_d;
      conv_cnt_q  <= conv_cnt_d;
      cfg_valid_q <= cfg_valid_d;
      err_early_q <= err_early_d;
      err_short_q <= err_short_d;
    end
  end

  // tx_q[11] drives DOUT; shifting zeros in leaves DOUT low after bit 0.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    tx_d        = tx_q;
    result_d    = result_q;
    cfg_d       = cfg_q;
    frame_cnt_d = frame_cnt_q;
    conv_cnt_d  = conv_cnt_q;
    cfg_valid_d = 1'b0;
    err_early_d = 1'b0;
    err_short_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          tx_d      = result_q;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          if (bit_cnt_q >= CFG_BITS) begin
            cfg_d       = shreg_q;
            cfg_valid_d = 1'b1;
          end else begin
            err_short_d = 1'b1;
          end
          frame_cnt_d = frame_cnt_q + 16'd1;
          conv_cnt_d  = CONV_W'(CONV_CYCLES - 1);
          tx_d        = '0;
          state_d     = CONVERT;
        end else begin
          if (sclk_rise) begin
            if (bit_cnt_q < CFG_BITS) begin
              shreg_d = {shreg_q[CFG_W-2:0], din_s};
            end
            if (bit_cnt_q != 4'hF) begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
          if (sclk_fall) begin
            tx_d = {tx_q[RES_W-2:0], 1'b0};
          end
        end
      end
      CONVERT: begin
        if (cs_fall) begin
          err_early_d = 1'b1;
          state_d     = SHIFT;
          bit_cnt_d   = '0;
          tx_d        = '0;
        end else if (conv_cnt_q == '0) begin
          result_d = cfg_to_result(cfg_q, sample_table);
          state_d  = IDLE;
        end else begin
          conv_cnt_d = conv_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign spi.adc_dout = tx_q[RES_W-1];
  assign cfg_word     = cfg_q;
  assign cfg_valid    = cfg_valid_q;
  assign busy         = (state_q == CONVERT);
  assign err_early    = err_early_q;
  assign err_short    = err_short_q;
  assign frame_count  = frame_cnt_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Scoreboarded bench for adc_spi_responder: drives SPI frames as a master and
// compares each returned word against a channel-table reference model.
`timescale 1ns/1ps
module tb_adc_spi_responder;
  import adc_emu_pkg::*;

  localparam int unsigned CONV = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  adc_spi_responder_if sif ();
  logic [TBL_W-1:0] sample_table;
  logic [5:0]       cfg_word;
  logic             cfg_valid, busy, err_early, err_short;
  logic [15:0]      frame_count;

  adc_spi_responder #(.CONV_CYCLES(CONV), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .spi          (sif.slave),
    .sample_table (sample_table),
    .cfg_word     (cfg_word),
    .cfg_valid    (cfg_valid),
    .busy         (busy),
    .err_early    (err_early),
    .err_short    (err_short),
    .frame_count  (frame_count)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model state
  logic [11:0] tbl_m [8];
  logic [15:0] exp_q [$];
  logic [5:0]  m_cfg;
  logic [11:0] m_result, m_next;
  logic        m_pending, m_gap_long;
  logic [15:0] m_fc;
  int unsigned exp_cfgv = 0, exp_short = 0, exp_early = 0;
  int unsigned cnt_cfgv = 0, cnt_short = 0, cnt_early = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_table();
    for (int ch = 0; ch < 8; ch++) sample_table[12*ch +: 12] = tbl_m[ch];
  endtask

  // Channel = 4*S1 + 2*S0 + O/S; bipolar offsets by half scale; SLP or differential reads 0.
  function automatic logic [11:0] ref_sample(input logic [5:0] cfg);
    int ch;
    int v;
    ch = 4 * int'(cfg[3]) + 2 * int'(cfg[2]) + int'(cfg[4]);
    v  = int'(tbl_m[ch]);
    if (cfg[0] == 1'b1 || cfg[5] == 1'b0) return 12'd0;
    if (cfg[1] == 1'b0) v = (v + 2048) % 4096;
    return 12'(v);
  endfunction

  task automatic frame(input logic [5:0] cfg, input int nsclk, input int gap);
    logic early;
    early = m_pending && !m_gap_long;
    if (m_pending && m_gap_long) m_result = m_next;
    m_pending = 1'b0;
    if (nsclk == 16) exp_q.push_back(early ? 16'h0000 : {m_result, 4'h0});
    if (early) exp_early++;
    @(negedge clk);
    sif.adc_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nsclk; i++) begin
      sif.adc_din = (i < 6) ? cfg[5-i] : 1'b0;
      repeat (8) @(negedge clk);
      sif.adc_sclk = 1'b1;
      repeat (8) @(negedge clk);
      sif.adc_sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    sif.adc_cs_n = 1'b1;
    if (nsclk >= 6) begin
      m_cfg = cfg;
      exp_cfgv++;
    end else begin
      exp_short++;
    end
    m_fc       = m_fc + 16'd1;
    m_next     = ref_sample(m_cfg);
    m_pending  = 1'b1;
    m_gap_long = (gap >= 100);
    repeat (gap) @(negedge clk);
  endtask

  task automatic checkpoint(input string tag);
    check({tag, "_cfg_word"}, 32'(cfg_word), 32'(m_cfg));
    check({tag, "_frame_count"}, 32'(frame_count), 32'(m_fc));
    check({tag, "_cfg_valid_pulses"}, cnt_cfgv, exp_cfgv);
    check({tag, "_err_short_pulses"}, cnt_short, exp_short);
    check({tag, "_err_early_pulses"}, cnt_early, exp_early);
  endtask

  initial begin : pulse_counter
    forever begin
      @(negedge clk);
      if (cfg_valid === 1'b1) cnt_cfgv++;
      if (err_short === 1'b1) cnt_short++;
      if (err_early === 1'b1) cnt_early++;
    end
  end

  // Master-side receiver: samples DOUT on SCLK rise, scores full 16-clock frames.
  initial begin : monitor
    logic [15:0] rx;
    logic [15:0] e;
    int          nbits;
    rx    = '0;
    nbits = 0;
    forever begin
      @(posedge sif.adc_sclk or negedge sif.adc_cs_n or posedge sif.adc_cs_n);
      if (sif.adc_cs_n === 1'b1) begin
        if (nbits == 16) begin
          if (exp_q.size() == 0) begin
            check("dout_unexpected_frame", 32'(rx), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("dout_word", 32'(rx), 32'(e));
          end
        end
        nbits = 0;
      end else if (sif.adc_sclk === 1'b1) begin
        rx    = {rx[14:0], sif.adc_dout};
        nbits = nbits + 1;
      end else begin
        rx    = '0;
        nbits = 0;
      end
    end
  end

  initial begin : stimulus
    logic [2:0] c;
    logic [5:0] rc;
    sif.adc_sclk = 1'b0;
    sif.adc_cs_n = 1'b1;
    sif.adc_din  = 1'b0;
    reset        = 1'b1;
    for (int ch = 0; ch < 8; ch++) tbl_m[ch] = 12'($urandom);
    tbl_m[0] = 12'hABC;
    tbl_m[1] = 12'h123;
    apply_table();
    m_cfg = 6'b100010; m_result = '0; m_next = '0;
    m_pending = 1'b0; m_gap_long = 1'b1; m_fc = '0;

    repeat (4) @(negedge clk);
    check("reset_dout", 32'(sif.adc_dout), 0);
    check("reset_cfg_word", 32'(cfg_word), 32'h22);
    check("reset_busy", 32'(busy), 0);
    check("reset_frame_count", 32'(frame_count), 0);
    check("reset_pulses", {29'd0, cfg_valid, err_short, err_early}, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Back-to-back ch0 reads
    frame(6'b100010, 16, 100);
    frame(6'b100010, 16, 100);
    checkpoint("s1");

    // O/S selects odd channel, then sweep every channel
    frame(6'b110010, 16, 100);
    frame(6'b100010, 16, 100);
    for (int i = 0; i < 8; i++) begin
      c = 3'(i);
      frame({1'b1, c[0], c[2], c[1], 1'b1, 1'b0}, 16, 100);
    end
    frame(6'b100010, 16, 100);
    checkpoint("s2");

    // Bipolar offset and sleep
    tbl_m[0] = 12'h000;
    apply_table();
    frame(6'b100000, 16, 100);
    frame(6'b100011, 16, 100);
    frame(6'b100010, 16, 100);
    checkpoint("s3");

    // Early CS_N fall aborts the pending conversion
    tbl_m[0] = 12'hABC;
    apply_table();
    frame(6'b100010, 16, 100);
    frame(6'b110010, 16, 10);
    frame(6'b100010, 16, 100);
    frame(6'b100010, 16, 100);
    checkpoint("s4");

    // Short frame, then frame counter wrap
    frame(6'b110011, 4, 100);
    checkpoint("s5_short");
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    m_fc = 16'hFFFF;
    @(negedge clk);
    check("preload_frame_count", 32'(frame_count), 32'hFFFF);
    frame(6'b100010, 16, 100);
    check("wrap_frame_count", 32'(frame_count), 0);
    checkpoint("s5_wrap");

    // Randomised frames, table updates, short frames and early falls
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        tbl_m[$urandom_range(0, 7)] = 12'($urandom);
        apply_table();
      end
      rc = 6'($urandom);
      frame(rc, ($urandom_range(0, 5) == 0) ? 4 : 16, ($urandom_range(0, 3) == 0) ? 10 : 100);
    end
    frame(6'b100010, 16, 100);
    checkpoint("rand");

    // Reset in the middle of a frame after five SCLK rises
    tbl_m[0] = 12'hABC;
    apply_table();
    @(negedge clk);
    sif.adc_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      sif.adc_din = 1'b1;
      repeat (8) @(negedge clk);
      sif.adc_sclk = 1'b1;
      repeat (8) @(negedge clk);
      sif.adc_sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_dout", 32'(sif.adc_dout), 0);
    check("midreset_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    m_cfg = 6'b100010; m_result = '0; m_pending = 1'b0; m_gap_long = 1'b1; m_fc = '0;
    repeat (8) @(negedge clk);
    sif.adc_cs_n = 1'b1;
    repeat (100) @(negedge clk);
    checkpoint("s6_after_reset");
    frame(6'b100010, 16, 100);
    frame(6'b100010, 16, 100);
    checkpoint("s6");
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
